dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data RAM port (7-bit word address, 4-bit byte-enable, 32-bit data) between two requesters.
  - Requester 0 is the CPU memory stage behind the MIO bus.
  - Requester 1 is the debug/loader port: switch-driven memory dump and program preload.
- Fixed priority to requester 0, with an aging counter that guarantees requester 1 is served.
- Sits between the MIO bus RAM-side signals and dmem, and serialises every access through a 3-state FSM.

Parameters:
- AW, 7, RAM word-address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive lost arbitrations after which requester 1 wins; legal range 1..15

Ports:
- clk  in  1  system clock; RAM is written on the same edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request; held until m0_ack
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_amp  in  4  requester 0 byte enables
- m0_addr  in  AW  requester 0 word address
- m0_wdata  in  DW  requester 0 write data
- m0_ack  out  1  one-cycle completion pulse to requester 0
- m0_rdata  out  DW  requester 0 read data, valid while m0_ack=1
- m1_req, m1_we, m1_amp, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, for requester 1
- ram_we  out  1  RAM write enable
- ram_amp  out  4  RAM byte enables
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data
- busy  out  1  high whenever state != IDLE
- m0_stall  out  1  m0_req & ~m0_ack; the CPU pipeline freezes on this

Behaviour:
- Reset (synchronous) clears the following; all outputs read 0 from the first cycle after the reset edge:
  - state to IDLE
  - owner, wait_cnt, cmd registers
  - m0_rdata, m1_rdata
  - acks
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's we/amp/addr/wdata into cmd registers, set owner, go to ACCESS.
- Arbitration, evaluated in IDLE only:
  - Only one requester asserting: that requester wins.
  - Both asserting and wait_cnt < MAX_WAIT: requester 0 wins and wait_cnt increments.
  - Both asserting and wait_cnt == MAX_WAIT: requester 1 wins.
  - wait_cnt clears whenever requester 1 is granted.
  - wait_cnt is 4 bits and saturates; it never wraps.
- ACCESS (one cycle):
  - ram_addr, ram_amp and ram_wdata are driven from the cmd registers.
  - ram_we = cmd_we & ~rst, so an asserted reset suppresses the write on that edge.
  - Reads capture ram_rdata into the owner's rdata register at the end of the cycle.
  - Writes leave the rdata register unchanged.
  - Next state is ACK.
- ACK (one cycle):
  - The owner's ack is 1 and its rdata is valid.
  - The RAM outputs are all 0.
  - Next state is IDLE.
- Outside ACCESS, ram_we, ram_amp, ram_addr and ram_wdata are all 0.
- Latency:
  - req sampled in IDLE at cycle t: RAM access at t+1, ack at t+2.
  - Minimum request-to-request spacing is 3 cycles.
- Requester obligation:
  - Drop req, or present a new command, on the edge that ends its ack cycle.
  - IDLE then samples the updated req, so no access is ever double-served.
- Requester 0 request arriving while requester 1 owns the port: waits, with no preemption.
- rdata for the non-owner holds its last value.
- Reset asserted in ACCESS or ACK:
  - Access is aborted and no ack is issued.
  - No RAM write occurs on the reset edge.
- cmd registers load only on the IDLE->ACCESS transition. Changes on m*_addr/wdata after grant do not affect the access in flight.

Test Plan:
- Reset, then m0 read of addr 5 (RAM[5]=0xDEADBEEF) -> ram_addr=5 and ram_we=0 at t+1; m0_ack=1 and m0_rdata=0xDEADBEEF at t+2; busy high for t+1..t+2.
- m1 write addr 0x7F, amp 0011, data 0x12345678 -> ram_we=1 for exactly one cycle with amp 0011; m1_ack at t+2; m1_rdata unchanged.
- m0 and m1 both requesting continuously, MAX_WAIT=4 -> grant order m0,m0,m0,m0,m1 repeating; wait_cnt returns to 0 after each m1 grant.
- m1 alone requesting with wait_cnt=0 -> immediate grant; m0 raising req during m1's ACCESS -> m0_stall high; m0 served next, ack 3 cycles after m1_ack.
- rst asserted during an m0 write ACCESS cycle -> ram_we=0 on that edge; no m0_ack; state IDLE; all outputs 0 next cycle.
- m0 changes addr from 3 to 9 in the ACCESS cycle -> ram_addr stays 3; ack data is from addr 3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data RAM port between two requesters.
//   Requester 0 (m0_*) is the CPU memory stage; requester 1 (m1_*) is the
//   debug/loader port. Requester 0 has fixed priority, but an aging counter
//   lets requester 1 win after MAX_WAIT consecutive lost arbitrations.
//   Every access is serialised IDLE -> ACCESS -> ACK (3 cycles minimum).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m<n>_req/we/amp   request, write(1)/read(0), byte enables
//   m<n>_addr/wdata   word address and write data
//   m<n>_ack          one-cycle completion pulse
//   m<n>_rdata        read data, valid while m<n>_ack is high
//   ram_we/amp/addr/wdata  RAM command, non-zero only in ACCESS
//   ram_rdata         RAM combinational read data
//   busy              high whenever the FSM is not idle
//   m0_stall          m0_req & ~m0_ack, freezes the CPU pipeline
module dmem_arbiter #(
  parameter int unsigned AW       = 7,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_amp,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_amp,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [3:0]    ram_amp,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          m0_stall
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e        state_q;
  logic          owner_q;     // 0: requester 0, 1: requester 1
  logic [3:0]    wait_cnt_q;  // consecutive arbitrations requester 1 has lost
  logic          cmd_we_q;
  logic [3:0]    cmd_amp_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;
  logic          m0_ack_q;
  logic          m1_ack_q;

  logic grant1;
  logic in_access;

  // Requester 1 wins when alone, or when it has aged out against requester 0.
  assign grant1 = m1_req & (~m0_req | (wait_cnt_q >= MaxWait));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      wait_cnt_q  <= 4'd0;
      cmd_we_q    <= 1'b0;
      cmd_amp_q   <= 4'd0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          if (m0_req | m1_req) begin
            state_q <= StAccess;
            owner_q <= grant1;
            if (grant1) begin
              cmd_we_q    <= m1_we;
              cmd_amp_q   <= m1_amp;
              cmd_addr_q  <= m1_addr;
              cmd_wdata_q <= m1_wdata;
              wait_cnt_q  <= 4'd0;
            end else begin
              cmd_we_q    <= m0_we;
              cmd_amp_q   <= m0_amp;
              cmd_addr_q  <= m0_addr;
              cmd_wdata_q <= m0_wdata;
              // Only a contested loss ages requester 1; saturate, never wrap.
              if (m1_req && (wait_cnt_q != 4'hF)) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
              end
            end
          end
        end
        StAccess: begin
          state_q <= StAck;
          if (!cmd_we_q) begin
            if (owner_q) begin
              m1_rdata_q <= ram_rdata;
            end else begin
              m0_rdata_q <= ram_rdata;
            end
          end
          m0_ack_q <= ~owner_q;
          m1_ack_q <= owner_q;
        end
        StAck: begin
          state_q  <= StIdle;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_access = (state_q == StAccess);

  // Gating with ~rst keeps a reset edge that lands in ACCESS from writing RAM.
  assign ram_we    = in_access & cmd_we_q & ~rst;
  assign ram_amp   = in_access ? cmd_amp_q : 4'd0;
  assign ram_addr  = in_access ? cmd_addr_q : '0;
  assign ram_wdata = in_access ? cmd_wdata_q : '0;

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = (state_q != StIdle);
  assign m0_stall = m0_req & ~m0_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single transactions,
// hand-written multi-cycle sequences and a randomized phase checked against
// a behavioural model (reference memory + aging arbitration rule).
module tb_dmem_arbiter;

  localparam int AW       = 7;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_ack;
  logic [3:0]    m0_amp;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack;
  logic [3:0]    m1_amp;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_we;
  logic [3:0]    ram_amp;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          busy, m0_stall;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_amp(ram_amp), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .m0_stall(m0_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Bench-side RAM: combinational read, byte-masked write on the clock edge.
  logic [31:0] mem [128];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] = merge(mem[ram_addr], ram_wdata, ram_amp);

  // Reference model state.
  logic [31:0] ref_mem [128];
  logic [31:0] exp_rd [2];
  int          lost;

  int checks   = 0;
  int failures = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic req, input logic we, input logic [3:0] amp,
                       input logic [6:0] addr, input logic [31:0] wdata);
    if (r == 0) begin
      m0_req = req; m0_we = we; m0_amp = amp; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_amp = amp; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic drop(input int r);
    if (r == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  function automatic logic ack_of(input int r);
    return (r == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input int r);
    return (r == 0) ? m0_rdata : m1_rdata;
  endfunction

  typedef struct {
    int          r;
    logic        we;
    logic [3:0]  amp;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;  // expected read data (reads only)
  } vec_t;

  vec_t vecs [9];

  // One uncontested transaction; called with the DUT idle, #1 after an edge.
  task automatic txn(input vec_t v);
    int o;
    o = 1 - v.r;
    drive(v.r, 1'b1, v.we, v.amp, v.addr, v.wdata);
    chk1("txn_idle_busy", busy, 1'b0);
    step();  // ACCESS
    chk1("txn_acc_busy", busy, 1'b1);
    chk1("txn_acc_we", ram_we, v.we);
    chk32("txn_acc_addr", 32'(ram_addr), 32'(v.addr));
    chk32("txn_acc_amp", 32'(ram_amp), 32'(v.amp));
    chk32("txn_acc_wdata", ram_wdata, v.wdata);
    chk1("txn_acc_noack", ack_of(v.r), 1'b0);
    step();  // ACK
    chk1("txn_ack", ack_of(v.r), 1'b1);
    chk1("txn_other_noack", ack_of(o), 1'b0);
    chk1("txn_ack_busy", busy, 1'b1);
    chk1("txn_ack_ramwe", ram_we, 1'b0);
    chk32("txn_ack_ramaddr", 32'(ram_addr), 32'd0);
    if (!v.we) exp_rd[v.r] = v.exp;
    else ref_mem[v.addr] = merge(ref_mem[v.addr], v.wdata, v.amp);
    chk32("txn_rdata", rdata_of(v.r), exp_rd[v.r]);
    chk32("txn_other_rdata", rdata_of(o), exp_rd[o]);
    drop(v.r);
    step();  // IDLE
    chk1("txn_done_busy", busy, 1'b0);
    chk1("txn_done_ack", ack_of(v.r), 1'b0);
  endtask

  // Randomized-phase per-requester pending command.
  logic        pend [2];
  logic        c_we [2];
  logic [3:0]  c_amp [2];
  logic [6:0]  c_addr [2];
  logic [31:0] c_wdata [2];

  initial begin
    int k;
    int who;
    int w;
    int o;

    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h33333333;
    mem[9] = 32'h99999999;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    lost = 0;

    vecs[0] = '{0, 1'b0, 4'hF, 7'h05, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1, 1'b1, 4'h3, 7'h7F, 32'h12345678, 32'h0};
    vecs[2] = '{0, 1'b0, 4'hF, 7'h7F, 32'h0, 32'h00005678};
    vecs[3] = '{1, 1'b0, 4'hF, 7'h7F, 32'h0, 32'h00005678};
    vecs[4] = '{0, 1'b1, 4'hF, 7'h10, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{0, 1'b1, 4'h8, 7'h10, 32'h11223344, 32'h0};
    vecs[6] = '{1, 1'b0, 4'hF, 7'h10, 32'h0, 32'h11A5A5A5};
    vecs[7] = '{1, 1'b1, 4'h4, 7'h05, 32'hCAFEF00D, 32'h0};
    vecs[8] = '{0, 1'b0, 4'hF, 7'h05, 32'h0, 32'hDEFEBEEF};

    drive(0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    rst = 1'b1;
    step();
    step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_m0_ack", m0_ack, 1'b0);
    chk1("rst_m1_ack", m1_ack, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk32("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk32("rst_m0_rdata", m0_rdata, 32'd0);
    chk32("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) txn(vecs[i]);

    // Address change after grant must not affect the access in flight.
    drive(0, 1'b1, 1'b0, 4'hF, 7'd3, 32'h0);
    step();
    m0_addr = 7'd9;
    #1;
    chk32("addrchg_ram_addr", 32'(ram_addr), 32'd3);
    step();
    chk1("addrchg_ack", m0_ack, 1'b1);
    chk32("addrchg_rdata", m0_rdata, 32'h33333333);
    exp_rd[0] = 32'h33333333;
    drop(0);
    step();

    // m1 alone, m0 arrives during m1's ACCESS: no preemption, m0 follows.
    drive(1, 1'b1, 1'b0, 4'hF, 7'd9, 32'h0);
    step();
    chk1("stall_m1_owns", ram_addr == 7'd9, 1'b1);
    drive(0, 1'b1, 1'b0, 4'hF, 7'd5, 32'h0);
    #1;
    chk1("stall_high_acc", m0_stall, 1'b1);
    step();
    chk1("stall_m1_ack", m1_ack, 1'b1);
    chk1("stall_high_ack", m0_stall, 1'b1);
    chk32("stall_m1_rdata", m1_rdata, 32'h99999999);
    exp_rd[1] = 32'h99999999;
    drop(1);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (m0_ack) begin
        k = i;
        break;
      end
    end
    chk32("stall_ack_gap", 32'(k), 32'd3);
    chk32("stall_m0_rdata", m0_rdata, 32'hDEFEBEEF);
    chk1("stall_low_on_ack", m0_stall, 1'b0);
    exp_rd[0] = 32'hDEFEBEEF;
    drop(0);
    step();

    // Both requesting continuously: m0 x MAX_WAIT, then m1, repeating.
    drive(0, 1'b1, 1'b0, 4'hF, 7'd3, 32'h0);
    drive(1, 1'b1, 1'b0, 4'hF, 7'd9, 32'h0);
    for (int g = 0; g < 2 * (MAX_WAIT + 1); g++) begin
      step();  // ACCESS
      step();  // ACK
      who = m1_ack ? 1 : (m0_ack ? 0 : -1);
      chk32("arb_grant", 32'(who), (g % (MAX_WAIT + 1) == MAX_WAIT) ? 32'd1 : 32'd0);
      step();  // IDLE
    end
    exp_rd[0] = 32'h33333333;
    drop(0);
    drop(1);
    step();

    // Reset during an m0 write ACCESS: no write, no ack, everything cleared.
    drive(0, 1'b1, 1'b1, 4'hF, 7'h20, 32'h5555AAAA);
    step();
    chk1("rstacc_we_before", ram_we, 1'b1);
    rst = 1'b1;
    drop(0);
    #1;
    chk1("rstacc_we_gated", ram_we, 1'b0);
    step();
    chk1("rstacc_busy", busy, 1'b0);
    chk1("rstacc_m0_ack", m0_ack, 1'b0);
    chk1("rstacc_ram_we", ram_we, 1'b0);
    chk32("rstacc_ram_wdata", ram_wdata, 32'd0);
    chk32("rstacc_m0_rdata", m0_rdata, 32'd0);
    chk32("rstacc_m1_rdata", m1_rdata, 32'd0);
    chk1("rstacc_m0_stall", m0_stall, 1'b0);
    chk32("rstacc_mem", mem[32], ref_mem[32]);
    rst = 1'b0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    lost = 0;
    step();
    chk1("rstacc_no_late_ack", m0_ack, 1'b0);

    // Randomized traffic against the behavioural model.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 300; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r]    = 1'b1;
          c_we[r]    = 1'($urandom_range(0, 1));
          c_amp[r]   = 4'($urandom_range(1, 15));
          c_addr[r]  = 7'($urandom_range(0, 15));
          c_wdata[r] = $urandom;
        end
        drive(r, pend[r], c_we[r], c_amp[r], c_addr[r], c_wdata[r]);
      end
      if (!pend[0] && !pend[1]) begin
        step();
        chk1("rnd_idle_busy", busy, 1'b0);
        continue;
      end
      // Requester 1 wins alone, or after losing MAX_WAIT contested rounds.
      if (pend[0] && pend[1]) begin
        if (lost >= MAX_WAIT) begin
          w = 1;
          lost = 0;
        end else begin
          w = 0;
          lost++;
        end
      end else if (pend[1]) begin
        w = 1;
        lost = 0;
      end else begin
        w = 0;
      end
      o = 1 - w;
      step();  // ACCESS
      chk32("rnd_addr", 32'(ram_addr), 32'(c_addr[w]));
      chk1("rnd_we", ram_we, c_we[w]);
      chk32("rnd_amp", 32'(ram_amp), 32'(c_amp[w]));
      chk32("rnd_wdata", ram_wdata, c_wdata[w]);
      step();  // ACK
      chk1("rnd_ack", ack_of(w), 1'b1);
      chk1("rnd_other_noack", ack_of(o), 1'b0);
      if (c_we[w]) ref_mem[c_addr[w]] = merge(ref_mem[c_addr[w]], c_wdata[w], c_amp[w]);
      else exp_rd[w] = ref_mem[c_addr[w]];
      chk32("rnd_rdata", rdata_of(w), exp_rd[w]);
      chk32("rnd_other_rdata", rdata_of(o), exp_rd[o]);
      pend[w] = 1'b0;
      drop(w);
      step();  // IDLE
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
